// File: rtl/ps_parse_ctrl_pkg.sv
// Shared constants and types for the parameter-set / slice-header parse sequencer.
// NAL type codes, VCL type ranges, parser select codes and controller states.
package ps_parse_ctrl_pkg;

    localparam logic [5:0] NAL_VPS = 6'd32;
    localparam logic [5:0] NAL_SPS = 6'd33;
    localparam logic [5:0] NAL_PPS = 6'd34;

    // VCL slice types occupy 0..VCL_LO_MAX and VCL_HI_MIN..VCL_HI_MAX.
    localparam logic [5:0] VCL_LO_MAX = 6'd9;
    localparam logic [5:0] VCL_HI_MIN = 6'd16;
    localparam logic [5:0] VCL_HI_MAX = 6'd21;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_VPS   = 3'd1,
        SEL_SPS   = 3'd2,
        SEL_PPS   = 3'd3,
        SEL_SLICE = 3'd4
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DONE,
        ST_SKIP
    } state_e;

endpackage

// File: rtl/ps_parse_ctrl_nal_type_classify.sv
// Maps an HEVC nal_unit_type to the parser select code that owns it.
// Unsupported types map to SEL_NONE.
module ps_parse_ctrl_nal_type_classify
    import ps_parse_ctrl_pkg::*;
(
    input  logic [5:0] nal_type_i,
    output logic [2:0] sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        if (nal_type_i == NAL_VPS) begin
            sel_o = SEL_VPS;
        end else if (nal_type_i == NAL_SPS) begin
            sel_o = SEL_SPS;
        end else if (nal_type_i == NAL_PPS) begin
            sel_o = SEL_PPS;
        end else if ((nal_type_i <= VCL_LO_MAX) ||
                     ((nal_type_i >= VCL_HI_MIN) && (nal_type_i <= VCL_HI_MAX))) begin
            sel_o = SEL_SLICE;
        end
    end

endmodule

// File: rtl/ps_parse_ctrl.sv
// Sequencer that hands the shared bitstream reader to one syntax parser per NAL,
// pulses its restart, muxes its consume request, and aborts it on a hang.
module ps_parse_ctrl
    import ps_parse_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMO_W          = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_nal_valid,
    input  logic [5:0] i_nal_unit_type,
    input  logic       i_bs_ready,
    input  logic       i_vps_done,
    input  logic       i_sps_done,
    input  logic       i_pps_done,
    input  logic       i_slice_done,
    input  logic [3:0] i_vps_forward_len,
    input  logic [3:0] i_sps_forward_len,
    input  logic [3:0] i_pps_forward_len,
    input  logic [3:0] i_slice_forward_len,
    output logic       o_parser_rst,
    output logic       o_vps_en,
    output logic       o_sps_en,
    output logic       o_pps_en,
    output logic       o_slice_en,
    output logic [3:0] o_forward_len,
    output logic       o_skip_nal,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_timeout,
    output logic [2:0] o_sel
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;

    logic [2:0] nal_sel;
    logic       sel_done;
    logic [3:0] sel_fwd;
    logic       en_act;

    ps_parse_ctrl_nal_type_classify u_classify (
        .nal_type_i (i_nal_unit_type),
        .sel_o      (nal_sel)
    );

    // Only the owning parser's done flag and consume request are ever observed.
    always_comb begin
        sel_done = 1'b0;
        sel_fwd  = '0;
        case (sel_q)
            SEL_VPS:   begin sel_done = i_vps_done;   sel_fwd = i_vps_forward_len;   end
            SEL_SPS:   begin sel_done = i_sps_done;   sel_fwd = i_sps_forward_len;   end
            SEL_PPS:   begin sel_done = i_pps_done;   sel_fwd = i_pps_forward_len;   end
            SEL_SLICE: begin sel_done = i_slice_done; sel_fwd = i_slice_forward_len; end
            default:   ;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a branch that skips one would infer a latch.
        state_d       = state_q;
        sel_d         = sel_q;
        tmo_d         = tmo_q;
        timeout_d     = timeout_q;
        en_act        = 1'b0;
        o_parser_rst  = 1'b0;
        o_done        = 1'b0;
        o_skip_nal    = 1'b0;
        o_forward_len = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_nal_valid) begin
                    if (sel_e'(nal_sel) != SEL_NONE) begin
                        sel_d   = sel_e'(nal_sel);
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_CLR: begin
                o_parser_rst = 1'b1;
                en_act       = 1'b1;
                tmo_d        = '0;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                en_act        = i_bs_ready;
                o_forward_len = i_bs_ready ? sel_fwd : 4'd0;
                tmo_d         = tmo_q + 1'b1;
                // A finish on the last allowed cycle still counts as a normal finish.
                if (sel_done) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    sel_d     = SEL_NONE;
                    state_d   = ST_SKIP;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                sel_d   = SEL_NONE;
                state_d = ST_SKIP;
            end
            ST_SKIP: begin
                o_skip_nal = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_NONE;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_vps_en   = en_act && (sel_q == SEL_VPS);
    assign o_sps_en   = en_act && (sel_q == SEL_SPS);
    assign o_pps_en   = en_act && (sel_q == SEL_PPS);
    assign o_slice_en = en_act && (sel_q == SEL_SLICE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_timeout  = timeout_q;
    assign o_sel      = sel_q;

endmodule

// File: tb/tb_ps_parse_ctrl.sv
// Scoreboard bench for ps_parse_ctrl: stimulus scripts each NAL from the
// documented latencies and queues per-cycle expectations; a monitor compares.
module tb_ps_parse_ctrl;

    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_nal_valid;
    logic [5:0] i_nal_unit_type;
    logic       i_bs_ready;
    logic       i_vps_done, i_sps_done, i_pps_done, i_slice_done;
    logic [3:0] i_vps_forward_len, i_sps_forward_len, i_pps_forward_len, i_slice_forward_len;
    logic       o_parser_rst, o_vps_en, o_sps_en, o_pps_en, o_slice_en;
    logic [3:0] o_forward_len;
    logic       o_skip_nal, o_busy, o_done, o_timeout;
    logic [2:0] o_sel;

    ps_parse_ctrl #(.TIMEOUT_CYCLES(TMO), .TMO_W(13)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_nal_valid         (i_nal_valid),
        .i_nal_unit_type     (i_nal_unit_type),
        .i_bs_ready          (i_bs_ready),
        .i_vps_done          (i_vps_done),
        .i_sps_done          (i_sps_done),
        .i_pps_done          (i_pps_done),
        .i_slice_done        (i_slice_done),
        .i_vps_forward_len   (i_vps_forward_len),
        .i_sps_forward_len   (i_sps_forward_len),
        .i_pps_forward_len   (i_pps_forward_len),
        .i_slice_forward_len (i_slice_forward_len),
        .o_parser_rst        (o_parser_rst),
        .o_vps_en            (o_vps_en),
        .o_sps_en            (o_sps_en),
        .o_pps_en            (o_pps_en),
        .o_slice_en          (o_slice_en),
        .o_forward_len       (o_forward_len),
        .o_skip_nal          (o_skip_nal),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_timeout           (o_timeout),
        .o_sel               (o_sel)
    );

    always #5 clk = ~clk;

    // en is {slice, pps, sps, vps}
    typedef struct packed {
        logic       rst;
        logic [3:0] en;
        logic [3:0] fwd;
        logic       skip;
        logic       busy;
        logic       done;
        logic       tmo;
        logic [2:0] sel;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    bit tmo_sticky = 1'b0;
    int bs_mode    = 0;    // 0 random, 1 always high, 2 high on odd RUN cycles
    int fwd_fix    = -1;   // -1 random consume requests, else fixed value
    int junk_fix   = -1;   // -1 random type for ignored NAL pulses, else that type

    function automatic logic [2:0] ref_sel(input int t);
        if (t == 32) return 3'd1;
        if (t == 33) return 3'd2;
        if (t == 34) return 3'd3;
        if ((t >= 0 && t <= 9) || (t >= 16 && t <= 21)) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] cur_fwd(input logic [2:0] s);
        case (s)
            3'd1:    return i_vps_forward_len;
            3'd2:    return i_sps_forward_len;
            3'd3:    return i_pps_forward_len;
            3'd4:    return i_slice_forward_len;
            default: return 4'd0;
        endcase
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e     = '0;
        e.tmo = tmo_sticky;
        return e;
    endfunction

    task automatic push(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance to just after the next rising edge and redraw the free-running inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        i_nal_valid  = 1'b0;
        i_vps_done   = 1'b0;
        i_sps_done   = 1'b0;
        i_pps_done   = 1'b0;
        i_slice_done = 1'b0;
        i_bs_ready   = 1'($urandom);
        i_vps_forward_len   = (fwd_fix < 0) ? 4'($urandom) : 4'(fwd_fix);
        i_sps_forward_len   = (fwd_fix < 0) ? 4'($urandom) : 4'(fwd_fix);
        i_pps_forward_len   = (fwd_fix < 0) ? 4'($urandom) : 4'(fwd_fix);
        i_slice_forward_len = (fwd_fix < 0) ? 4'($urandom) : 4'(fwd_fix);
    endtask

    task automatic junk(input bit noise);
        if (noise && ($urandom_range(0, 2) == 0)) begin
            i_nal_valid     = 1'b1;
            i_nal_unit_type = (junk_fix < 0) ? 6'($urandom) : 6'(junk_fix);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            push(idle_obs(), "idle");
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        push(idle_obs(), "pre_rst");
        tick();
        rst = 1'b0;
        tmo_sticky = 1'b0;
        push(idle_obs(), "rst_state");
    endtask

    // One NAL: done_cyc is the RUN cycle (1-based) on which the owner reports done;
    // rst_at > 0 asserts reset on that RUN cycle instead of letting it finish.
    task automatic run_nal(input int t, input int done_cyc, input bit noise, input int rst_at);
        logic [2:0] sel;
        logic [3:0] oh;
        logic [3:0] dv;
        int         n;
        bit         fin;
        obs_t       e;
        sel = ref_sel(t);
        oh  = (sel == 3'd0) ? 4'd0 : (4'd1 << (sel - 3'd1));

        tick();
        i_nal_valid     = 1'b1;
        i_nal_unit_type = 6'(t);
        push(idle_obs(), "accept");

        if (sel == 3'd0) begin
            tick();
            junk(noise);
            e = idle_obs(); e.skip = 1'b1; e.busy = 1'b1;
            push(e, "unsup_skip");
            return;
        end

        tick();
        junk(noise);
        e = idle_obs(); e.rst = 1'b1; e.en = oh; e.busy = 1'b1; e.sel = sel;
        push(e, "clear");

        fin = (done_cyc <= TMO);
        n   = fin ? done_cyc : TMO;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bs_mode == 1)      i_bs_ready = 1'b1;
            else if (bs_mode == 2) i_bs_ready = k[0];
            dv = noise ? 4'($urandom) : 4'd0;
            dv = (dv & ~oh) | ((k == done_cyc) ? oh : 4'd0);
            {i_slice_done, i_pps_done, i_sps_done, i_vps_done} = dv;
            junk(noise);
            if (k == rst_at) rst = 1'b1;
            e = idle_obs(); e.busy = 1'b1; e.sel = sel;
            e.en  = i_bs_ready ? oh : 4'd0;
            e.fwd = i_bs_ready ? cur_fwd(sel) : 4'd0;
            push(e, "run");
            if (k == rst_at) begin
                tick();
                rst = 1'b0;
                tmo_sticky = 1'b0;
                push(idle_obs(), "after_mid_rst");
                return;
            end
        end

        if (fin) begin
            tick();
            junk(noise);
            e = idle_obs(); e.done = 1'b1; e.busy = 1'b1; e.sel = sel;
            push(e, "done");
        end else begin
            tmo_sticky = 1'b1;
        end

        tick();
        junk(noise);
        e = idle_obs(); e.skip = 1'b1; e.busy = 1'b1;
        push(e, fin ? "skip" : "timeout_skip");
    endtask

    // Monitor: the DUT presents a full output vector every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string tag;
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            a.rst  = o_parser_rst;
            a.en   = {o_slice_en, o_pps_en, o_sps_en, o_vps_en};
            a.fwd  = o_forward_len;
            a.skip = o_skip_nal;
            a.busy = o_busy;
            a.done = o_done;
            a.tmo  = o_timeout;
            a.sel  = o_sel;
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s @%0t: got rst=%b en=%b fwd=%0d skip=%b busy=%b done=%b tmo=%b sel=%0d; want rst=%b en=%b fwd=%0d skip=%b busy=%b done=%b tmo=%b sel=%0d",
                         tag, $time, a.rst, a.en, a.fwd, a.skip, a.busy, a.done, a.tmo, a.sel,
                         e.rst, e.en, e.fwd, e.skip, e.busy, e.done, e.tmo, e.sel);
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r, dc, ra;
        rst = 1'b1;
        i_nal_valid = 1'b0; i_nal_unit_type = '0; i_bs_ready = 1'b0;
        i_vps_done = 1'b0; i_sps_done = 1'b0; i_pps_done = 1'b0; i_slice_done = 1'b0;
        i_vps_forward_len = '0; i_sps_forward_len = '0;
        i_pps_forward_len = '0; i_slice_forward_len = '0;

        tick();
        push(idle_obs(), "reset_hold");
        tick();
        rst = 1'b0;
        push(idle_obs(), "reset_release");
        idle_cycles(2);

        // VPS, reader always ready, done on the 20th RUN cycle.
        bs_mode = 1;
        run_nal(32, 20, 1'b0, 0);
        idle_cycles(1);

        // PPS with fixed consume request 5 and ready pattern 1,0,1.
        bs_mode = 2; fwd_fix = 5;
        run_nal(34, 3, 1'b0, 0);
        bs_mode = 0; fwd_fix = -1;
        idle_cycles(1);

        // SEI is unsupported.
        run_nal(39, 0, 1'b0, 0);

        // Slice that never finishes: aborted after TMO RUN cycles, flag sticks until reset.
        run_nal(1, 1000000, 1'b0, 0);
        idle_cycles(3);
        run_nal(33, 4, 1'b1, 0);
        do_reset();

        // VPS with ignored SPS NAL pulses and foreign done flags, then reset mid-RUN.
        junk_fix = 33;
        run_nal(32, 15, 1'b1, 0);
        run_nal(32, 40, 1'b1, 10);
        junk_fix = -1;
        idle_cycles(1);

        // Done on the last allowed RUN cycle wins over the timeout.
        run_nal(32, TMO, 1'b0, 0);
        idle_cycles(1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: t = 32;
                1: t = 33;
                2: t = 34;
                3: t = $urandom_range(0, 9);
                4: t = $urandom_range(16, 21);
                default: begin
                    t = $urandom_range(0, 63);
                    while (ref_sel(t) != 3'd0) t = $urandom_range(0, 63);
                end
            endcase
            dc = $urandom_range(1, 25);
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, dc) : 0;
            run_nal(t, dc, 1'b1, ra);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps_parse_ctrl.md
Name: ps_parse_ctrl

Overview:
- Top-level sequencer for the parameter-set and slice-header parsers (vps, sps, pps, slice_header).
- Receives a decoded NAL unit type and selects the one parser that owns the shared bitstream reader.
- Generates per-parser enable and restart pulses, muxes the selected parser's o_forward_len to the reader, detects completion and guards against hangs.
- Sits between the NAL header/start-code logic and the syntax parsers.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles a parser may run before it is aborted.
- TMO_W, 13: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_nal_valid  in  1  one-cycle pulse; NAL header parsed, type valid
- i_nal_unit_type  in  6  HEVC nal_unit_type
- i_bs_ready  in  1  bitstream reader holds at least 8 valid bits
- i_vps_done  in  1  vps parser state equals `vps_end
- i_sps_done, i_pps_done, i_slice_done  in  1 each  parser end flags
- i_vps_forward_len, i_sps_forward_len, i_pps_forward_len, i_slice_forward_len  in  4 each  parser consume requests
- o_parser_rst  out  1  one-cycle restart pulse to the selected parser
- o_vps_en, o_sps_en, o_pps_en, o_slice_en  out  1 each  parser clock enables (at most one high)
- o_forward_len  out  4  bits the reader consumes this cycle
- o_skip_nal  out  1  pulse; reader discards the rest of the current NAL
- o_busy  out  1  a NAL is being handled
- o_done  out  1  pulse; selected parser finished normally
- o_timeout  out  1  sticky; a parser was aborted (cleared by rst)
- o_sel  out  3  0 none, 1 vps, 2 sps, 3 pps, 4 slice

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- NAL type classification:
  - 32 → vps; 33 → sps; 34 → pps.
  - 0–9 and 16–21 → slice.
  - Any other type → unsupported.
- IDLE:
  - On i_nal_valid with a supported type: latch o_sel, go to CLR, o_busy=1.
  - On i_nal_valid with an unsupported type: go to SKIP.
  - i_nal_valid is ignored in every state except IDLE.
- CLR (exactly 1 cycle):
  - o_parser_rst=1 and the selected en=1, so the parser returns to its reset state.
  - Timeout counter cleared; next state RUN.
- RUN:
  - Selected en = i_bs_ready; all other enables are 0.
  - o_forward_len = selected parser's forward_len when i_bs_ready=1, else 0. This path is combinational from the registered o_sel and state.
  - The counter increments every RUN cycle.
  - Selected done=1 → DONE. This takes priority over timeout in the same cycle.
  - Counter reaches TIMEOUT_CYCLES-1 → set o_timeout, go to SKIP.
  - Done flags of non-selected parsers are ignored.
- DONE (1 cycle): o_done=1, enables 0, o_forward_len=0, then go to SKIP. This discards trailing RBSP and extension bits.
- SKIP (1 cycle): o_skip_nal=1, o_sel cleared, then IDLE with o_busy=0.
- Outside RUN, o_forward_len=0 and all enables are 0, except the selected enable during CLR.
- Latency:
  - i_nal_valid to first RUN cycle: 2 clocks.
  - Parser done to o_done: 1 clock.
  - o_done to o_busy low: 2 clocks.
- rst asserted mid-RUN forces IDLE next edge; no o_done and no o_skip_nal are emitted.
- i_bs_ready low throughout RUN stalls the parser, but the timeout counter still advances.

Decomposition:
- Shared defines file holds:
  - NAL type constants: NAL_VPS=32, NAL_SPS=33, NAL_PPS=34.
  - VCL type ranges.
  - o_sel codes SEL_NONE..SEL_SLICE.
  - Controller state codes: IDLE, CLR, RUN, DONE, SKIP.
  - `vps_end, already shared with the vps parser.
- One natural sub-module, nal_type_classify: a combinational function from type to sel code. Mux and FSM stay inline.

Test Plan:
- Type 32 pulse, i_bs_ready=1, vps done after 20 RUN cycles:
  - o_parser_rst at cycle 1, o_vps_en from cycle 1.
  - o_done at cycle 22, o_skip_nal at 23, o_busy low at 24.
- Type 34 with i_pps_forward_len=5 in RUN and i_bs_ready toggling 1,0,1:
  - o_forward_len sequence 5,0,5.
  - o_pps_en follows i_bs_ready; o_vps_en, o_sps_en and o_slice_en stay 0.
- Type 39 (SEI): no enable ever asserted; o_skip_nal pulse 1 cycle after i_nal_valid; o_done never asserted.
- Type 1 with i_slice_done never asserted: o_timeout set after 4096 RUN cycles, o_skip_nal next cycle, o_timeout stays 1 until rst.
- Second i_nal_valid (type 33) during RUN of a vps: ignored, o_sel stays 1. rst mid-RUN: all outputs 0 on the next cycle with no o_done.
- i_vps_done and timeout both hitting in the same cycle: o_done=1 and o_timeout stays 0.
